// File: rtl/mat_tile_cache.sv
// Small cache of WIDTH x WIDTH tiles with row/column/wrapped-diagonal access and an
// in-place multi-cycle transpose that stalls the command port while it runs.
module mat_tile_cache #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CACHE_SIZE = 4,
  parameter int unsigned ADDR_W     = $clog2(CACHE_SIZE),
  parameter int unsigned PARAM_W    = 1 + $clog2(WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [ADDR_W-1:0]       cmd_addr1,
  input  logic [ADDR_W-1:0]       cmd_addr2,
  input  logic [PARAM_W-1:0]      cmd_param,
  input  logic [WIDTH*DATA_W-1:0] wr_data,
  output logic                    rd_valid,
  output logic [WIDTH*DATA_W-1:0] rd_data,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpWrRow  = 3'd1;
  localparam logic [2:0] OpWrCol  = 3'd2;
  localparam logic [2:0] OpWrDiag = 3'd3;
  localparam logic [2:0] OpRdRow  = 3'd4;
  localparam logic [2:0] OpRdCol  = 3'd5;
  localparam logic [2:0] OpRdDiag = 3'd6;
  localparam logic [2:0] OpXpose  = 3'd7;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StXpose = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [IdxW-1:0]         r_q, r_d;
  logic [ADDR_W-1:0]       tgt_q, tgt_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    err_q, err_d;
  logic [WIDTH*DATA_W-1:0] rd_data_q, rd_data_d;

  // Tile storage is deliberately left out of reset.
  logic [DATA_W-1:0] mem_q [CACHE_SIZE][WIDTH][WIDTH];
  logic [DATA_W-1:0] mem_d [CACHE_SIZE][WIDTH][WIDTH];

  logic [ADDR_W-1:0] e_tile [WIDTH];
  logic [IdxW-1:0]   e_row  [WIDTH];
  logic [IdxW-1:0]   e_col  [WIDTH];

  logic accept, param_ok, is_wr, is_rd;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StXpose);
  assign accept    = cmd_valid && cmd_ready;
  assign param_ok  = (cmd_param < PARAM_W'(WIDTH));
  assign is_wr     = (cmd_op == OpWrRow) || (cmd_op == OpWrCol) || (cmd_op == OpWrDiag);
  assign is_rd     = (cmd_op == OpRdRow) || (cmd_op == OpRdCol) || (cmd_op == OpRdDiag);

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

  // Per-element (tile, row, col) location shared by reads and writes.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      e_tile[i] = cmd_addr1;
      e_row[i]  = IdxW'(i);
      e_col[i]  = IdxW'(cmd_param);
      case (cmd_op)
        OpWrRow, OpRdRow: begin
          e_row[i] = IdxW'(cmd_param);
          e_col[i] = IdxW'(i);
        end
        OpWrDiag, OpRdDiag: begin
          if (i <= int'(cmd_param)) begin
            e_col[i] = IdxW'(int'(cmd_param) - i);
          end else begin
            // Anti-diagonal wraps into the secondary tile.
            e_tile[i] = cmd_addr2;
            e_col[i]  = IdxW'(int'(WIDTH) + int'(cmd_param) - i);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    tgt_d      = tgt_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    rd_data_d  = rd_data_q;
    mem_d      = mem_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_op == OpXpose) begin
            state_d = StXpose;
            r_d     = '0;
            tgt_d   = cmd_addr1;
          end else if (cmd_op != OpNop && !param_ok) begin
            err_d = 1'b1;
          end else if (is_wr) begin
            for (int i = 0; i < WIDTH; i++) begin
              mem_d[e_tile[i]][e_row[i]][e_col[i]] = wr_data[i*DATA_W +: DATA_W];
            end
          end else if (is_rd) begin
            rd_valid_d = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
              rd_data_d[i*DATA_W +: DATA_W] = mem_q[e_tile[i]][e_row[i]][e_col[i]];
            end
          end
        end
      end
      StXpose: begin
        // Step r swaps the strict upper part of row r with column r.
        for (int j = 0; j < WIDTH; j++) begin
          if (j > int'(r_q)) begin
            mem_d[tgt_q][r_q][IdxW'(j)] = mem_q[tgt_q][IdxW'(j)][r_q];
            mem_d[tgt_q][IdxW'(j)][r_q] = mem_q[tgt_q][r_q][IdxW'(j)];
          end
        end
        if (r_q == IdxW'(WIDTH - 1)) begin
          state_d = StIdle;
        end else begin
          r_d = r_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      r_q        <= '0;
      tgt_q      <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      tgt_q      <= tgt_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mat_tile_cache.sv
// Self-checking bench for mat_tile_cache: directed vector table, hand-written transpose and
// reset-abort sequences, then random commands against a tile-array reference model.
module tb_mat_tile_cache;

  localparam int W  = 4;
  localparam int DW = 16;
  localparam int CS = 4;
  localparam int AW = 2;
  localparam int PW = 3;
  localparam int VW = W * DW;

  localparam logic [2:0] NOP = 3'd0, WR_ROW = 3'd1, WR_COL = 3'd2, WR_DIAG = 3'd3;
  localparam logic [2:0] RD_ROW = 3'd4, RD_COL = 3'd5, RD_DIAG = 3'd6, XPOSE = 3'd7;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr1 = '0;
  logic [AW-1:0] cmd_addr2 = '0;
  logic [PW-1:0] cmd_param = '0;
  logic [VW-1:0] wr_data = '0;
  logic          rd_valid;
  logic [VW-1:0] rd_data;
  logic          busy;
  logic          err;

  always #5 clock = ~clock;

  mat_tile_cache #(
    .WIDTH     (W),
    .DATA_W    (DW),
    .CACHE_SIZE(CS),
    .ADDR_W    (AW),
    .PARAM_W   (PW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr1(cmd_addr1),
    .cmd_addr2(cmd_addr2),
    .cmd_param(cmd_param),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    logic [2:0]    op;
    int            a1;
    int            a2;
    int            p;
    logic [VW-1:0] wd;
    logic          ev;
    logic          ee;
    logic [VW-1:0] ed;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain tile array plus the last read vector.
  logic [DW-1:0] m [CS][W][W];
  logic [VW-1:0] m_rd = '0;
  logic          m_valid = 1'b0;
  logic          m_err = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [VW-1:0] v4(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input int a1, input int a2, input int p,
                              input logic [VW-1:0] wd, input logic ev, input logic ee,
                              input logic [VW-1:0] ed);
    vec_t v;
    v.op = op; v.a1 = a1; v.a2 = a2; v.p = p; v.wd = wd; v.ev = ev; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  task automatic drive(input logic [2:0] op, input int a1, input int a2, input int p,
                       input logic [VW-1:0] wd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr1 = AW'(a1);
    cmd_addr2 = AW'(a2);
    cmd_param = PW'(p);
    wr_data   = wd;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic model_accept(input logic [2:0] op, input int a1, input int a2, input int p,
                              input logic [VW-1:0] wd);
    logic [DW-1:0] tmp [W][W];
    int t, row, col, kind;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (op == NOP) return;
    if (op == XPOSE) begin
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++) tmp[r][c] = m[a1][c][r];
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++) m[a1][r][c] = tmp[r][c];
      return;
    end
    if (p >= W) begin
      m_err = 1'b1;
      return;
    end
    kind = (int'(op) - 1) % 3;
    for (int i = 0; i < W; i++) begin
      if (kind == 0) begin
        t = a1; row = p; col = i;
      end else if (kind == 1) begin
        t = a1; row = i; col = p;
      end else begin
        t = (i <= p) ? a1 : a2; row = i; col = (p - i + W) % W;
      end
      if (op <= WR_DIAG) m[t][row][col] = wd[i*DW +: DW];
      else m_rd[i*DW +: DW] = m[t][row][col];
    end
    m_valid = (op >= RD_ROW);
  endtask

  // Issue one command from idle, then check the cycle after acceptance against the model.
  task automatic cmd(input logic [2:0] op, input int a1, input int a2, input int p,
                     input logic [VW-1:0] wd, input string tag);
    int n, nr;
    drive(op, a1, a2, p, wd);
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) check({tag, " ready_timeout"}, VW'(cmd_ready), VW'(1));
    model_accept(op, a1, a2, p, wd);
    step();
    idle();
    check({tag, " rd_valid"}, VW'(rd_valid), VW'(m_valid));
    check({tag, " err"}, VW'(err), VW'(m_err));
    check({tag, " rd_data"}, rd_data, m_rd);
    if (op == XPOSE) begin
      n  = 0;
      nr = 0;
      while (busy && n < 20) begin
        if (cmd_ready) nr++;
        step();
        n++;
      end
      check({tag, " busy_cycles"}, VW'(n), VW'(W));
      check({tag, " ready_while_busy"}, VW'(nr), VW'(0));
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic [VW-1:0] wd;
    int n, nr, k;

    // Reset state
    idle();
    repeat (3) step();
    check("reset cmd_ready", VW'(cmd_ready), VW'(1));
    check("reset busy", VW'(busy), VW'(0));
    check("reset rd_valid", VW'(rd_valid), VW'(0));
    check("reset err", VW'(err), VW'(0));
    check("reset rd_data", rd_data, '0);
    reset_n = 1'b1;
    step();

    // Directed vector table
    for (int r = 0; r < W; r++)
      tbl.push_back(mk(WR_ROW, 1, 0, r, v4(16*r, 16*r+1, 16*r+2, 16*r+3), 0, 0, '0));
    tbl.push_back(mk(RD_COL, 1, 0, 2, '0, 1, 0, v4(2, 18, 34, 50)));
    for (int r = 0; r < W; r++)
      tbl.push_back(mk(WR_ROW, 0, 0, r, v4(4*r+1, 4*r+2, 4*r+3, 4*r+4), 0, 0, v4(2, 18, 34, 50)));
    for (int r = 0; r < W; r++)
      tbl.push_back(mk(WR_ROW, 2, 0, r, v4(4*r+101, 4*r+102, 4*r+103, 4*r+104), 0, 0,
                       v4(2, 18, 34, 50)));
    tbl.push_back(mk(RD_DIAG, 0, 2, 1, '0, 1, 0, v4(2, 5, 112, 115)));
    tbl.push_back(mk(NOP, 0, 0, 0, '0, 0, 0, v4(2, 5, 112, 115)));
    tbl.push_back(mk(RD_ROW, 0, 0, 5, '0, 0, 1, v4(2, 5, 112, 115)));
    tbl.push_back(mk(NOP, 0, 0, 0, '0, 0, 0, v4(2, 5, 112, 115)));
    tbl.push_back(mk(WR_COL, 0, 0, 4, v4(9, 9, 9, 9), 0, 1, v4(2, 5, 112, 115)));
    tbl.push_back(mk(RD_ROW, 0, 0, 0, '0, 1, 0, v4(1, 2, 3, 4)));
    tbl.push_back(mk(RD_COL, 2, 0, 3, '0, 1, 0, v4(104, 108, 112, 116)));

    foreach (tbl[i]) begin
      cmd(tbl[i].op, tbl[i].a1, tbl[i].a2, tbl[i].p, tbl[i].wd, $sformatf("vec%0d", i));
      check($sformatf("vec%0d exp_valid", i), VW'(rd_valid), VW'(tbl[i].ev));
      check($sformatf("vec%0d exp_err", i), VW'(err), VW'(tbl[i].ee));
      check($sformatf("vec%0d exp_data", i), rd_data, tbl[i].ed);
    end

    // Transpose tile 1 with a row read held behind it
    drive(XPOSE, 1, 0, 0, '0);
    model_accept(XPOSE, 1, 0, 0, '0);
    step();
    drive(RD_ROW, 1, 0, 0, '0);
    n  = 0;
    nr = 0;
    while (busy && n < 20) begin
      if (!cmd_ready) nr++;
      step();
      n++;
    end
    check("xpose busy_cycles", VW'(n), VW'(4));
    check("xpose ready_low_cycles", VW'(nr), VW'(4));
    check("xpose ready_after", VW'(cmd_ready), VW'(1));
    model_accept(RD_ROW, 1, 0, 0, '0);
    step();
    idle();
    check("xpose held_read valid", VW'(rd_valid), VW'(1));
    check("xpose held_read data", rd_data, v4(0, 16, 32, 48));
    check("xpose held_read model", rd_data, m_rd);
    step();
    check("rd_valid pulse", VW'(rd_valid), VW'(0));

    // Diagonal write then read on consecutive cycles
    wd = {$urandom, $urandom};
    cmd(WR_DIAG, 3, 0, 2, wd, "diag_wr");
    cmd(RD_DIAG, 3, 0, 2, '0, "diag_rd");
    check("diag roundtrip", rd_data, wd);

    // Fill every tile so the model and DUT both hold defined data
    for (int t = 0; t < CS; t++)
      for (int r = 0; r < W; r++) cmd(WR_ROW, t, 0, r, {$urandom, $urandom}, "fill");

    // Reset in the middle of a transpose at step r=2
    drive(XPOSE, 1, 0, 0, '0);
    step();
    idle();
    step();
    step();
    check("abort busy_before", VW'(busy), VW'(1));
    reset_n = 1'b0;
    #1;
    check("abort busy", VW'(busy), VW'(0));
    check("abort cmd_ready", VW'(cmd_ready), VW'(1));
    check("abort rd_valid", VW'(rd_valid), VW'(0));
    check("abort err", VW'(err), VW'(0));
    check("abort rd_data", rd_data, '0);
    step();
    reset_n = 1'b1;
    m_rd = '0;
    step();
    for (int r = 0; r < W; r++) cmd(RD_ROW, 3, 0, r, '0, $sformatf("abort tile3 row%0d", r));
    for (int r = 0; r < W; r++) cmd(WR_ROW, 1, 0, r, {$urandom, $urandom}, "refill");

    // Random commands against the model
    for (int it = 0; it < 300; it++) begin
      k = $urandom_range(0, 7);
      cmd(3'(k), $urandom_range(0, CS-1), $urandom_range(0, CS-1), $urandom_range(0, 5),
          {$urandom, $urandom}, $sformatf("rand%0d op%0d", it, k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
